// File: rtl/switch_box_config_loader_if.sv
// Config stream and status bundle between the fabric config controller
// (master) and one switch_box_config_loader (slave).
interface switch_box_config_loader_if #(
  parameter int unsigned W_IN  = 8,
  parameter int unsigned CFG_W = 72
);
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [W_IN-1:0]  in_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [CFG_W-1:0] c;

  modport master (
    output start, abort, in_valid, in_data,
    input  in_ready, busy, done, err, c
  );

  modport slave (
    input  start, abort, in_valid, in_data,
    output in_ready, busy, done, err, c
  );
endinterface

// File: rtl/switch_box_config_loader.sv
// Word-serial configuration loader for universal_switch_box. Data words are
// assembled LSB-first into a shadow register; a trailing XOR checksum word
// decides whether the shadow is committed atomically to c.
module switch_box_config_loader #(
  parameter int unsigned WS   = 8,
  parameter int unsigned WD   = 8,
  parameter int unsigned W_IN = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  switch_box_config_loader_if.slave bus
);

  localparam int unsigned CFG_W  = WS*6 + (WD/2)*6;
  localparam int unsigned NWORDS = (CFG_W + W_IN - 1) / W_IN;
  localparam int unsigned CNT_W  = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [W_IN-1:0]  xor_q,    xor_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] c_q,      c_d;
  logic             done_q,   done_d;
  logic             err_q,    err_d;
  logic             hs;

  assign hs = bus.in_valid && (state_q != IDLE);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      xor_q    <= '0;
      shadow_q <= '0;
      c_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xor_q    <= xor_d;
      shadow_q <= shadow_d;
      c_q      <= c_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: word capture, running checksum, commit decision.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    shadow_d = shadow_q;
    c_d      = c_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          cnt_d   = '0;
          xor_d   = '0;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (hs) begin
          // Bit-wise select keeps the padding bits of the last word out of
          // the shadow while the full word still enters the checksum.
          for (int unsigned i = 0; i < CFG_W; i++) begin
            if ((i / W_IN) == 32'(cnt_q)) begin
              shadow_d[i] = bus.in_data[i % W_IN];
            end
          end
          xor_d = xor_q ^ bus.in_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NWORDS - 1)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (hs) begin
          state_d = IDLE;
          if (bus.in_data == xor_q) begin
            c_d    = shadow_q;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready = (state_q != IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.c        = c_q;

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Bench for switch_box_config_loader: a queue-based reference model checked
// every cycle against the main instance, plus literal expectations and a
// second WS=7 instance for the truncated last word.
module tb_switch_box_config_loader;

  localparam int unsigned NW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_box_config_loader_if #(.W_IN(8), .CFG_W(72)) bus ();
  switch_box_config_loader_if #(.W_IN(8), .CFG_W(66)) bus2 ();

  switch_box_config_loader #(.WS(8), .WD(8), .W_IN(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  switch_box_config_loader #(.WS(7), .WD(8), .W_IN(8)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is a list of accepted words; once NW words are
  // held the next accepted word is the checksum.
  bit          m_active = 1'b0;
  logic [7:0]  m_words[$];
  logic [71:0] m_c = '0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;

  always @(posedge clk) begin
    logic [7:0]  x;
    logic [71:0] acc;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0;
      m_words.delete();
      m_c = '0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active = 1'b1;
        m_words.delete();
      end
    end else if (bus.abort) begin
      m_active = 1'b0;
    end else if (bus.in_valid) begin
      if (m_words.size() < NW) begin
        m_words.push_back(bus.in_data);
      end else begin
        x = '0;
        acc = '0;
        foreach (m_words[k]) begin
          x = x ^ m_words[k];
          acc = acc | (72'(m_words[k]) << (8 * k));
        end
        if (bus.in_data == x) begin
          m_c = acc;
          m_done = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_active = 1'b0;
      end
    end
  end

  // Every-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",     72'(bus.busy),     72'(m_active));
      chk("in_ready", 72'(bus.in_ready), 72'(m_active));
      chk("done",     72'(bus.done),     72'(m_done));
      chk("err",      72'(bus.err),      72'(m_err));
      chk("c",        bus.c,             m_c);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send2(input logic [7:0] w);
    bus2.in_valid = 1'b1;
    bus2.in_data  = w;
    step();
    bus2.in_valid = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.in_valid = 1'b0; bus2.in_data = '0;

    // 1: reset with in_valid held high
    rst_n = 1'b0;
    step(); step();
    chk_en = 1'b1;
    chk("rst_c",        bus.c,              72'h0);
    chk("rst_in_ready", 72'(bus.in_ready),  72'h0);
    chk("rst_busy",     72'(bus.busy),      72'h0);
    chk("rst_done_err", 72'({bus.done, bus.err}), 72'h0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    step();

    // 2: good load 01..09, checksum 01
    pulse_start();
    chk("start_busy", 72'(bus.busy), 72'h1);
    for (int i = 1; i <= 9; i++) send(8'(i));
    send(8'h01);
    chk("t2_done", 72'(bus.done), 72'h1);
    chk("t2_busy", 72'(bus.busy), 72'h0);
    chk("t2_c",    bus.c, 72'h090807060504030201);
    step();
    chk("t2_done_pulse", 72'(bus.done), 72'h0);

    // 3: bad checksum leaves c alone
    pulse_start();
    for (int i = 8'h11; i <= 8'h19; i++) send(8'(i));
    send(8'h00);
    chk("t3_err",  72'(bus.err),  72'h1);
    chk("t3_done", 72'(bus.done), 72'h0);
    chk("t3_c",    bus.c, 72'h090807060504030201);
    step();

    // 4: abort with a word and a start presented; then a fresh load
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i));
    bus.abort = 1'b1; bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hC4;
    step();
    bus.abort = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
    chk("t4_busy", 72'(bus.busy), 72'h0);
    chk("t4_c",    bus.c, 72'h090807060504030201);
    step();
    pulse_start();
    for (int i = 0; i < 9; i++) send(8'hA0 + 8'(i));
    send(8'hA8);
    chk("t4_done", 72'(bus.done), 72'h1);
    chk("t4_c2",   bus.c, 72'hA8A7A6A5A4A3A2A1A0);

    // 5: back-to-back start in the done cycle, gaps and stray starts
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t5_b2b_busy", 72'(bus.busy), 72'h1);
    for (int i = 1; i <= 9; i++) begin
      int unsigned gap = $urandom_range(0, 3);
      for (int unsigned g = 0; g < gap; g++) begin
        bus.start = (g == 0);
        step();
      end
      bus.start = 1'b0;
      send(8'(i));
    end
    step(); step();
    send(8'h01);
    chk("t5_done", 72'(bus.done), 72'h1);
    chk("t5_c",    bus.c, 72'h090807060504030201);
    step();

    // reset mid-load clears c
    pulse_start();
    for (int i = 0; i < 3; i++) send(8'h33);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_c",    bus.c, 72'h0);
    chk("midrst_busy", 72'(bus.busy), 72'h0);
    step();

    // 6: WS=7 instance, truncated last word still in the checksum
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    for (int i = 0; i < 8; i++) send2(8'h00);
    send2(8'hFF);
    send2(8'hFF);
    chk("t6_done", 72'(bus2.done), 72'h1);
    chk("t6_c",    72'(bus2.c), 72'h3_0000_0000_0000_0000);
    step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
